// File: rtl/riva_fu_insn_queue.sv
// Per-FU instruction queue: accept/issue/commit pointers over a circular buffer; one-hot done pulse on commit.
// Latency: accept -> issue_valid_o 1 cycle, commit -> vinsn_done_o 1 cycle. Backpressure: insn_ready_o drops when
// every entry is awaiting commit. Optional RIVA_INSNQ_FLUSH_EN adds flush_i (drops unissued entries).
module riva_fu_insn_queue #(
  parameter int unsigned Depth        = 4,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned NrVInsn      = 8,
  parameter int unsigned VidWidth     = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    insn_valid_i,
  output logic                    insn_ready_o,
  input  logic [6:0]              insn_op_i,
  input  logic [VidWidth-1:0]     insn_vid_i,
  input  logic [PayloadWidth-1:0] insn_payload_i,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [6:0]              issue_op_o,
  output logic [VidWidth-1:0]     issue_vid_o,
  output logic [PayloadWidth-1:0] issue_payload_o,
  input  logic                    commit_i,
`ifdef RIVA_INSNQ_FLUSH_EN
  input  logic                    flush_i,
`endif
  output logic [VidWidth-1:0]     commit_vid_o,
  output logic [NrVInsn-1:0]      vinsn_done_o,
  output logic                    busy_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC   = CntW'(Depth);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(Depth - 1);

  logic [6:0]              op_q      [Depth];
  logic [VidWidth-1:0]     vid_q     [Depth];
  logic [PayloadWidth-1:0] payload_q [Depth];

  logic [IdxW-1:0]    acc_ptr, iss_ptr, cmt_ptr;
  logic [IdxW-1:0]    acc_ptr_n, iss_ptr_n, cmt_ptr_n;
  logic [CntW-1:0]    iss_cnt, cmt_cnt;
  logic [CntW-1:0]    iss_cnt_n, cmt_cnt_n;
  logic [NrVInsn-1:0] done_q;
  logic               acc_fire, iss_fire, cmt_fire, cmt_legal;

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    return (p == LastIdx) ? '0 : p + IdxW'(1);
  endfunction

  assign insn_ready_o  = (cmt_cnt < DepthC);
  assign issue_valid_o = (iss_cnt != '0);
  assign cmt_legal     = (cmt_cnt > iss_cnt);
  assign busy_o        = (cmt_cnt != '0);
  assign vinsn_done_o  = done_q;

  // Storage is never reset, so gate reads to keep outputs clean while invalid.
  assign issue_op_o      = issue_valid_o ? op_q[iss_ptr]      : '0;
  assign issue_vid_o     = issue_valid_o ? vid_q[iss_ptr]     : '0;
  assign issue_payload_o = issue_valid_o ? payload_q[iss_ptr] : '0;
  assign commit_vid_o    = cmt_legal     ? vid_q[cmt_ptr]     : '0;

  always_comb begin
    acc_fire = insn_valid_i & insn_ready_o;
    iss_fire = issue_valid_o & issue_ready_i;
    cmt_fire = commit_i & cmt_legal;
`ifdef RIVA_INSNQ_FLUSH_EN
    if (flush_i) begin
      acc_fire = 1'b0;
      iss_fire = 1'b0;
    end
`endif
    acc_ptr_n = acc_fire ? ptr_inc(acc_ptr) : acc_ptr;
    iss_ptr_n = iss_fire ? ptr_inc(iss_ptr) : iss_ptr;
    cmt_ptr_n = cmt_fire ? ptr_inc(cmt_ptr) : cmt_ptr;
    iss_cnt_n = iss_cnt + CntW'(acc_fire) - CntW'(iss_fire);
    cmt_cnt_n = cmt_cnt + CntW'(acc_fire) - CntW'(cmt_fire);
`ifdef RIVA_INSNQ_FLUSH_EN
    // Unissued entries vanish; issued ones remain and can still commit this cycle.
    if (flush_i) begin
      acc_ptr_n = iss_ptr;
      cmt_cnt_n = cmt_cnt - iss_cnt - CntW'(cmt_fire);
      iss_cnt_n = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_ptr <= '0;
      iss_ptr <= '0;
      cmt_ptr <= '0;
      iss_cnt <= '0;
      cmt_cnt <= '0;
      done_q  <= '0;
    end else begin
      acc_ptr <= acc_ptr_n;
      iss_ptr <= iss_ptr_n;
      cmt_ptr <= cmt_ptr_n;
      iss_cnt <= iss_cnt_n;
      cmt_cnt <= cmt_cnt_n;
      done_q  <= cmt_fire ? (NrVInsn'(1) << vid_q[cmt_ptr]) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_fire) begin
      op_q[acc_ptr]      <= insn_op_i;
      vid_q[acc_ptr]     <= insn_vid_i;
      payload_q[acc_ptr] <= insn_payload_i;
    end
  end

`ifdef RIVA_INSNQ_ASSERT_ON
  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i) commit_i |-> cmt_legal);
`endif

endmodule
